// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The optional checksum stage is controlled by IMEM_LOADER_CSUM_EN.
package imem_loader_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int DATA_W_DEF     = 8;
  localparam int LEN_ZERO_MEANS = 256;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  // LEN byte of zero encodes a full 256-byte program.
  function automatic logic [8:0] frame_len(input logic [7:0] len_byte);
    return (len_byte == 8'd0) ? 9'(LEN_ZERO_MEANS) : {1'b0, len_byte};
  endfunction

endpackage

// File: rtl/imem_loader_csum.sv
// Clearable running-sum accumulator with an equality compare output.
// Only instantiated by imem_loader when IMEM_LOADER_CSUM_EN is defined.
module loader_csum #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         add_en,
  input  logic [W-1:0] din,
  input  logic [W-1:0] cmp_val,
  output logic         match
);

  logic [W-1:0] sum_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_reg <= '0;
    end else if (clr) begin
      sum_reg <= '0;
    end else if (add_en) begin
      sum_reg <= sum_reg + din;
    end
  end

  assign match = (sum_reg == cmp_val);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream writer for instruction memory; holds the CPU in reset until loaded.
// Define IMEM_LOADER_CSUM_EN to require and verify a trailing checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                 ADDR_W    = ADDR_W_DEF,
  parameter int                 DATA_W    = DATA_W_DEF,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t     state_reg;
  state_t     state_next;
  logic [8:0] count_reg;
  logic [8:0] n_reg;
  logic       accept;
  logic       start_ok;
  logic       last_byte;
  logic       csum_match;

  assign in_ready  = (state_reg == LEN) || (state_reg == DATA) || (state_reg == CSUM);
  assign accept    = in_valid && in_ready;
  assign start_ok  = start && ((state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERROR));
  assign last_byte = ((count_reg + 9'd1) == n_reg);

`ifdef IMEM_LOADER_CSUM_EN
  logic error_reg;

  loader_csum #(.W(8)) u_csum (
    .clk     (clk),
    .reset   (reset),
    .clr     (start_ok),
    .add_en  (accept && (state_reg == DATA)),
    .din     (in_data),
    .cmp_val (in_data),
    .match   (csum_match)
  );

  assign error = error_reg;
`else
  assign csum_match = 1'b0;
  assign error      = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE, ERROR: if (start) state_next = LEN;
      LEN:               if (accept) state_next = DATA;
`ifdef IMEM_LOADER_CSUM_EN
      DATA:              if (accept && last_byte) state_next = CSUM;
      CSUM:              if (accept) state_next = csum_match ? DONE : ERROR;
`else
      DATA:              if (accept && last_byte) state_next = DONE;
`endif
      default:           state_next = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_reg.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      n_reg      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      error_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      imem_we   <= 1'b0;
      busy      <= (state_next == LEN) || (state_next == DATA) || (state_next == CSUM);
      done      <= (state_next == DONE);
      cpu_reset <= (state_next != DONE);
`ifdef IMEM_LOADER_CSUM_EN
      error_reg <= (state_next == ERROR);
`endif
      if (start_ok) begin
        count_reg <= '0;
      end
      if (accept && (state_reg == LEN)) begin
        n_reg <= frame_len(in_data);
      end
      if (accept && (state_reg == DATA)) begin
        imem_we    <= 1'b1;
        imem_addr  <= BASE_ADDR + ADDR_W'(count_reg);
        imem_wdata <= DATA_W'(in_data);
        count_reg  <= count_reg + 9'd1;
      end
    end
  end

  // csum_match is only consumed in the checksum build.
  logic unused_ok;
  assign unused_ok = csum_match;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction-memory interface. The CPU only reads instruction memory; this block fills it. It accepts a framed byte stream over a valid/ready handshake and writes each program byte into instruction memory. It holds the CPU in reset until a complete, checksum-verified program is loaded.

Parameters:
ADDR_W, 8, instruction-memory address width; matches the 8-bit PC.
DATA_W, 8, instruction width.
BASE_ADDR, 8'h00, address of the first program byte written.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
in_data  input  8  stream byte.
in_valid  input  1  in_data is valid.
in_ready  output  1  loader accepts a byte this cycle.
imem_we  output  1  instruction-memory write strobe, one cycle per byte.
imem_addr  output  ADDR_W  write address.
imem_wdata  output  DATA_W  write data.
cpu_reset  output  1  held high except in DONE.
busy  output  1  high in LEN, DATA and CSUM.
done  output  1  high while in DONE.
error  output  1  high while in ERROR.

Behaviour:
- Frame format: LEN byte, then N data bytes, then CSUM byte. N = LEN, except LEN = 0 means N = 256. CSUM = sum of the data bytes mod 256.
- Transfer rule: a byte is accepted on a rising clk edge with in_valid & in_ready both high. in_ready is combinational from state only, never from in_valid.
- in_ready = 1 in LEN, DATA and CSUM; 0 otherwise.
- Values during and after reset: state = IDLE, cpu_reset = 1, imem_we = 0, imem_addr = BASE_ADDR, imem_wdata = 0, busy = done = error = 0, byte counter = 0, accumulator = 0.
- IDLE -> LEN on start. This transition clears the counter and accumulator.
- LEN -> DATA on accepted byte; latch N.
- DATA, on each accepted byte:
  - register imem_we = 1, imem_addr = BASE_ADDR + count (mod 2^ADDR_W, wraps), imem_wdata = byte; the write appears the cycle after acceptance;
  - accumulator += byte (8-bit wrap);
  - count += 1;
  - on the Nth byte, go to CSUM.
- CSUM -> DONE if the accepted byte equals the accumulator, else -> ERROR. The outcome is visible the cycle after acceptance.
- In DONE: cpu_reset = 0, done = 1.
- In ERROR: cpu_reset = 1, error = 1. Already-written bytes are not rolled back.
- start in DONE or ERROR -> LEN: re-asserts cpu_reset the next cycle and clears the counter and accumulator.
- start while busy is ignored.
- start and an accepted byte never coincide, because in_ready = 0 wherever start is honoured.
- Stalls: in_valid low for any number of cycles stalls the load without timeout. imem_we stays low on cycles with no acceptance.
- Reset mid-load: immediate return to IDLE with cpu_reset = 1. A partially written memory is left as-is.

Optional Feature:
IMEM_LOADER_CSUM_EN.
- Defined: behaviour as above.
- Undefined: no CSUM state and no accumulator. After the Nth data byte, go DATA -> DONE; the last write and done assert on the same cycle. ERROR is unreachable and error is tied 0.

Decomposition:
- Package imem_loader_pkg: state enum (IDLE, LEN, DATA, CSUM, DONE, ERROR), LEN_ZERO_MEANS = 256, and the ADDR_W/DATA_W default constants.
- One sub-module, loader_csum: 8-bit clearable accumulator with add-enable and compare output. It is instantiated only under IMEM_LOADER_CSUM_EN.

Test Plan:
1. Basic load: start, then bytes 03, 21, 42, 63, C6.
   -> Writes (00,21), (01,42), (02,63).
   -> done = 1 and cpu_reset = 0 one cycle after C6 is accepted; error = 0.
2. Checksum mismatch: same frame with CSUM = 00.
   -> Three writes occur; error = 1; cpu_reset stays 1; done = 0.
   -> A subsequent start plus the correct frame reaches DONE.
3. Full-size load: LEN = 00, then data 00..FF, then CSUM 80.
   -> 256 writes at addresses 00..FF, each with data = address; done = 1.
   -> With BASE_ADDR = 8'hF0, the addresses wrap F0..FF, 00..EF.
4. Backpressure: frame from test 1 with in_valid toggled 1-0-0-1 per byte.
   -> Exactly 3 imem_we pulses, no duplicates; the result equals test 1.
5. Reset mid-load: assert reset after the 2nd data byte.
   -> Same cycle: state IDLE, busy = 0, cpu_reset = 1, in_ready = 0.
   -> No third write; start still required to reload.
6. start ignored while busy: pulse start during DATA.
   -> Counter unaffected; the frame completes normally.
   -> Without IMEM_LOADER_CSUM_EN, test 1 minus the C6 byte reaches DONE on the cycle of the 3rd write.
